// File: rtl/key_expand.sv
// AES-128/256 key schedule: expands the cipher key one word per cycle
// into 15 round keys and serves them through a registered read port.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int n = 0; n < 8; n++) begin
      if (y[n]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // multiplicative inverse as a^254, then the affine map
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    inv  = gmul(gmul(x240, x12), x2);
    s = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end
endmodule

module key_expand (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [3:0]   rounds_total,
  input  logic [255:0] key,
  input  logic [3:0]   round_key_no,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         en_o
);
  localparam int NR_128 = 10;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0] w [60];
  logic [5:0]  i;
  logic [7:0]  rcon;
  logic        nk8;
  logic [3:0]  nr;

  logic        load, last, valid_rt;
  logic        rot_sel, sub_only;
  logic [31:0] prev, old, sub_in, sub_out, temp;
  logic [5:0]  base;
  logic        rd_ok;
  logic [3:0]  rd_r;

  assign valid_rt = (rounds_total == 4'(NR_128))
                 || (rounds_total == 4'(NR_256));
  assign last = (i == (nk8 ? 6'd59 : 6'd43));

  always_comb begin
    state_nx = state;
    load = 1'b0;
    unique case (state)
      IDLE:
        if (en && valid_rt) begin
          load = 1'b1;
          state_nx = EXPAND;
        end
      EXPAND:
        if (last) state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  assign prev = w[i - 6'd1];
  assign old  = w[i - (nk8 ? 6'd8 : 6'd4)];
  assign rot_sel  = nk8 ? (i[2:0] == 3'd0) : (i[1:0] == 2'd0);
  assign sub_only = nk8 && (i[2:0] == 3'd4);
  assign sub_in   = rot_sel ? {prev[23:0], prev[31:24]} : prev;

  for (genvar g = 0; g < 4; g++) begin : g_sb
    aes_sbox u_sb (
      .a (sub_in[8*g +: 8]),
      .s (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp = prev;
    unique case (1'b1)
      rot_sel:  temp = sub_out ^ {rcon, 24'h0};
      sub_only: temp = sub_out;
      default:  temp = prev;
    endcase
  end

  assign rd_ok = (round_key_no <= nr) && (round_key_no <= 4'd14);
  assign rd_r  = rd_ok ? round_key_no : 4'd0;
  assign base  = {rd_r, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 60; k++) w[k] <= 32'h0;
      i <= 6'd0;
      rcon <= 8'h01;
      nk8 <= 1'b0;
      nr <= 4'd0;
      busy <= 1'b0;
      en_o <= 1'b0;
      round_key <= '0;
    end else begin
      en_o <= 1'b0;
      if (load) begin
        nk8 <= (rounds_total == 4'(NR_256));
        nr <= rounds_total;
        for (int k = 0; k < 8; k++)
          if (k < 4 || rounds_total == 4'(NR_256))
            w[k] <= key[255 - 32*k -: 32];
        i <= (rounds_total == 4'(NR_256)) ? 6'd8 : 6'd4;
        rcon <= 8'h01;
        busy <= 1'b1;
      end
      if (state == EXPAND) begin
        w[i] <= old ^ temp;
        i <= i + 6'd1;
        if (rot_sel)
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (last) begin
          busy <= 1'b0;
          en_o <= 1'b1;
        end
      end
      round_key <= rd_ok
        ? {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]}
        : 128'h0;
    end
  end
endmodule
